// File: rtl/occ_storage_server.sv
// Round-robin responder for four accelerator Occ read ports sharing one synchronous storage.
// Each port holds at most one request; reads are issued one per cycle and returned in issue order.
module occ_storage_server #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              storage_ce_1,
    input  logic              storage_ce_2,
    input  logic              storage_ce_3,
    input  logic              storage_ce_4,
    input  logic [ADDR_W-1:0] storage_addr_1,
    input  logic [ADDR_W-1:0] storage_addr_2,
    input  logic [ADDR_W-1:0] storage_addr_3,
    input  logic [ADDR_W-1:0] storage_addr_4,
    output logic [DATA_W-1:0] data_to_alu_1,
    output logic [DATA_W-1:0] data_to_alu_2,
    output logic [DATA_W-1:0] data_to_alu_3,
    output logic [DATA_W-1:0] data_to_alu_4,
    output logic              done_1,
    output logic              done_2,
    output logic              done_3,
    output logic              done_4,
    output logic              mem_ce,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [3:0]        ce_vec;
    logic [ADDR_W-1:0] addr_in [4];

    logic              pend_reg   [4];
    logic              issued_reg [4];
    logic [ADDR_W-1:0] addr_reg   [4];
    logic [DATA_W-1:0] data_reg   [4];
    logic              done_reg   [4];

    logic [3:0]        cand;
    logic [3:0]        ret_hot;
    logic              grant_valid;
    logic [1:0]        grant_id;

    logic              mem_ce_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [1:0]        rr_reg;

    // Tag stage i travels alongside the read issued i cycles earlier; stage RD_LAT meets mem_rdata.
    logic              tag_valid_reg [RD_LAT+1];
    logic [1:0]        tag_id_reg    [RD_LAT+1];

    assign ce_vec     = {storage_ce_4, storage_ce_3, storage_ce_2, storage_ce_1};
    assign addr_in[0] = storage_addr_1;
    assign addr_in[1] = storage_addr_2;
    assign addr_in[2] = storage_addr_3;
    assign addr_in[3] = storage_addr_4;

    always_comb begin
        ret_hot = '0;
        if (tag_valid_reg[RD_LAT]) begin
            ret_hot[tag_id_reg[RD_LAT]] = 1'b1;
        end
    end

    // First pending-but-unissued port at or after the rr pointer wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = rr_reg;
        for (int i = 0; i < 4; i++) begin
            if (!grant_valid && cand[rr_reg + 2'(i)]) begin
                grant_valid = 1'b1;
                grant_id    = rr_reg + 2'(i);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_port
            assign cand[gi] = pend_reg[gi] & ~issued_reg[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pend_reg[gi]   <= 1'b0;
                    issued_reg[gi] <= 1'b0;
                    addr_reg[gi]   <= '0;
                    data_reg[gi]   <= '0;
                    done_reg[gi]   <= 1'b0;
                end else begin
                    done_reg[gi] <= ret_hot[gi];
                    if (ret_hot[gi]) begin
                        // A strobe arriving now sees pend still set and is dropped.
                        data_reg[gi]   <= mem_rdata;
                        pend_reg[gi]   <= 1'b0;
                        issued_reg[gi] <= 1'b0;
                    end else begin
                        if (ce_vec[gi] && !pend_reg[gi]) begin
                            pend_reg[gi] <= 1'b1;
                            addr_reg[gi] <= addr_in[gi];
                        end
                        if (grant_valid && grant_id == 2'(gi)) begin
                            issued_reg[gi] <= 1'b1;
                        end
                    end
                end
            end
        end

        for (gi = 1; gi <= RD_LAT; gi++) begin : g_tag
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tag_valid_reg[gi] <= 1'b0;
                    tag_id_reg[gi]    <= '0;
                end else begin
                    tag_valid_reg[gi] <= tag_valid_reg[gi-1];
                    tag_id_reg[gi]    <= tag_id_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ce_reg       <= 1'b0;
            mem_addr_reg     <= '0;
            rr_reg           <= 2'd0;
            tag_valid_reg[0] <= 1'b0;
            tag_id_reg[0]    <= '0;
        end else begin
            mem_ce_reg       <= grant_valid;
            tag_valid_reg[0] <= grant_valid;
            tag_id_reg[0]    <= grant_id;
            if (grant_valid) begin
                mem_addr_reg <= addr_reg[grant_id];
                rr_reg       <= grant_id + 2'd1;
            end
        end
    end

    assign mem_ce        = mem_ce_reg;
    assign mem_addr      = mem_addr_reg;
    assign data_to_alu_1 = data_reg[0];
    assign data_to_alu_2 = data_reg[1];
    assign data_to_alu_3 = data_reg[2];
    assign data_to_alu_4 = data_reg[3];
    assign done_1        = done_reg[0];
    assign done_2        = done_reg[1];
    assign done_3        = done_reg[2];
    assign done_4        = done_reg[3];

endmodule
